serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 in_valid  input  1  operands a, b presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 out_valid  output  1  sum/cout valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 sum  output  WIDTH  result, a+b modulo 2^WIDTH.
REQ-011 cout  output  1  carry out of bit WIDTH-1.
REQ-012 busy  output  1  high while a bit-serial addition is in progress.

Function
REQ-013 Datapath SHALL be one shared 1-bit full-adder slice built from two half_adder instances (sum = x^y^c, carry = x&y | c&(x^y)), reused once per bit, LSB first.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding is implementation choice.
REQ-015 in_ready SHALL be 1 exactly when state==IDLE; busy SHALL be 1 exactly when state==RUN; out_valid SHALL be 1 exactly when state==DONE.
REQ-016 IDLE: on edge with in_valid&in_ready, capture a and b into shift registers, clear carry flop, clear bit counter, go to RUN; otherwise stay in IDLE.
REQ-017 RUN: each edge, feed operand LSBs and carry flop into slice, shift slice sum into result register MSB side (shift right), store slice carry, advance counter.
REQ-018 RUN SHALL last exactly WIDTH edges; on the WIDTH-th RUN edge go to DONE with sum and cout final.
REQ-019 Latency: out_valid SHALL rise WIDTH cycles after the accepting edge (edge T0 accept; edges T1..TWIDTH in RUN; out_valid high from TWIDTH).
REQ-020 DONE: sum and cout SHALL hold stable while out_valid&!out_ready; on edge with out_ready go to IDLE.
REQ-021 No accept in DONE; a new operand pair is accepted no earlier than the edge after the result handshake (throughput one result per WIDTH+2 cycles minimum).
REQ-022 in_valid while in RUN or DONE SHALL be ignored; a and b may change freely after the accepting edge without affecting the result.
REQ-023 out_ready outside DONE SHALL be ignored.
REQ-024 sum and cout outside DONE hold last computed value (don't-care for checking; must not be X after reset).
REQ-025 WIDTH=1: RUN lasts one edge; result equals a single full-adder evaluation with carry-in 0.
REQ-026 Bit counter SHALL be wide enough for WIDTH without wrap before terminal count.

Reset
REQ-027 rst high at an edge SHALL force state IDLE, sum=0, cout=0, carry flop=0, counter=0, in_ready=1, out_valid=0, busy=0, from any state.
REQ-028 Reset mid-RUN or in DONE SHALL abort the operation; no out_valid for the aborted pair.
REQ-029 rst has priority over every handshake in the same cycle.

Verification
REQ-030 WIDTH=8, a=0xFF, b=0x01, in_valid one cycle, out_ready=1 -> out_valid 8 cycles after accept, sum=0x00, cout=1, in_ready back 1 cycle later.
REQ-031 WIDTH=8, a=0xA5, b=0x5A, out_ready=0 for 5 cycles then 1 -> sum=0xFF, cout=0 held stable all 5 cycles; in_valid pulses during RUN/DONE ignored.
REQ-032 rst asserted at 4th RUN edge of a=0x80, b=0x80 -> next cycle in_ready=1, out_valid=0, sum=0, cout=0; following pair 0x03+0x04 -> sum=0x07, cout=0.
REQ-033 Back-to-back: in_valid held high with pairs (0x10,0x20),(0xF0,0x20) -> results 0x30/cout0 then 0x10/cout1, second accepted on edge after first result handshake.
REQ-034 WIDTH=1 exhaustive 4 pairs -> (0,0)->0/0, (0,1)->1/0, (1,0)->1/0, (1,1)->0/1, each out_valid 1 cycle after accept.
REQ-035 Random 1000 pairs WIDTH=8 against {cout,sum}=a+b reference model with random out_ready backpressure.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder with valid/ready operand and result handshakes
// One shared full-adder slice (two half adders) is reused LSB first for WIDTH cycles.

module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             ha0_s;
    logic             ha0_c;
    logic             ha1_s;
    logic             ha1_c;
    logic             slice_sum;
    logic             slice_carry;

    half_adder u_ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(ha0_s), .c(ha0_c));
    half_adder u_ha1 (.x(ha0_s),   .y(carry),   .s(ha1_s), .c(ha1_c));

    assign slice_sum   = ha1_s;
    assign slice_carry = ha0_c | ha1_c;

    // New sum bits enter at the MSB so that after WIDTH shifts bit 0 lands at position 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = slice_sum;
        end else begin : g_res_wn
            assign res_next = {slice_sum, res[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (busy) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= res_next;
            carry <= slice_carry;
            cnt   <= cnt + CW'(1);
        end
    end

    assign sum  = res;
    assign cout = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random scoreboard bench for serial_add_ctrl
// Instantiates an 8-bit and a 1-bit adder; expectations are queued on accept and popped on result handshake.

module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid8 = 1'b0;
    logic       in_ready8;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       out_valid8;
    logic       out_ready8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8;
    logic       busy8;

    logic       in_valid1 = 1'b0;
    logic       in_ready1;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       out_valid1;
    logic       out_ready1 = 1'b0;
    logic [0:0] sum1;
    logic       cout1;
    logic       busy1;

    int n_checks = 0;
    int n_err    = 0;

    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] e8;
    logic [1:0] e1;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .busy(busy8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid8 && in_ready8) q8.push_back({1'b0, a8} + {1'b0, b8});
            if (out_valid8 && out_ready8) begin
                check("sb8_pending", 32'(q8.size() != 0), 1);
                if (q8.size() != 0) begin
                    e8 = q8.pop_front();
                    check("sb8_result", {cout8, sum8}, e8);
                end
            end
            if (in_valid1 && in_ready1) q1.push_back({1'b0, a1} + {1'b0, b1});
            if (out_valid1 && out_ready1) begin
                check("sb1_pending", 32'(q1.size() != 0), 1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    check("sb1_result", {cout1, sum1}, e1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send8(input logic [7:0] av, input logic [7:0] bv);
        logic acc;
        in_valid8 = 1'b1;
        a8 = av;
        b8 = bv;
        acc = 1'b0;
        for (int k = 0; k < 200; k++) begin
            acc = in_ready8;
            tick();
            if (acc) break;
        end
        in_valid8 = 1'b0;
        check("send8_accept", acc, 1);
    endtask

    task automatic send1(input logic av, input logic bv);
        logic acc;
        in_valid1 = 1'b1;
        a1 = av;
        b1 = bv;
        acc = 1'b0;
        for (int k = 0; k < 50; k++) begin
            acc = in_ready1;
            tick();
            if (acc) break;
        end
        in_valid1 = 1'b0;
        check("send1_accept", acc, 1);
    endtask

    task automatic wait_valid8(output int n);
        n = 0;
        while (!out_valid8 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_valid1(output int n);
        n = 0;
        while (!out_valid1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        logic acc;
        logic [1:0] tbl1 [4];
        logic [7:0] ra;
        logic [7:0] rb;
        tbl1 = '{2'b00, 2'b01, 2'b01, 2'b10};

        // reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready8", in_ready8, 1);
        check("rst_out_valid8", out_valid8, 0);
        check("rst_busy8", busy8, 0);
        check("rst_sum8", sum8, 0);
        check("rst_cout8", cout8, 0);
        check("rst_in_ready1", in_ready1, 1);

        // 0xFF + 0x01 carries all the way out
        out_ready8 = 1'b1;
        send8(8'hFF, 8'h01);
        check("ff01_busy", busy8, 1);
        check("ff01_in_ready", in_ready8, 0);
        wait_valid8(n);
        check("ff01_latency", n, 8);
        check("ff01_sum", sum8, 8'h00);
        check("ff01_cout", cout8, 1);
        tick();
        check("ff01_in_ready_back", in_ready8, 1);
        check("ff01_out_valid_low", out_valid8, 0);

        // backpressure with ignored in_valid pulses during RUN and DONE
        out_ready8 = 1'b0;
        send8(8'hA5, 8'h5A);
        tick();
        tick();
        in_valid8 = 1'b1;
        a8 = 8'h00;
        b8 = 8'h00;
        tick();
        in_valid8 = 1'b0;
        wait_valid8(n);
        check("a55a_latency", n, 5);
        in_valid8 = 1'b1;
        a8 = 8'h11;
        b8 = 8'h22;
        for (int i = 0; i < 5; i++) begin
            check("a55a_hold_valid", out_valid8, 1);
            check("a55a_hold_sum", sum8, 8'hFF);
            check("a55a_hold_cout", cout8, 0);
            check("a55a_no_accept", in_ready8, 0);
            tick();
        end
        in_valid8 = 1'b0;
        out_ready8 = 1'b1;
        check("a55a_still_valid", out_valid8, 1);
        tick();
        check("a55a_in_ready", in_ready8, 1);

        // reset on the 4th RUN edge aborts 0x80 + 0x80
        send8(8'h80, 8'h80);
        tick();
        tick();
        tick();
        rst = 1'b1;
        q8.delete();
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready8, 1);
        check("abort_out_valid", out_valid8, 0);
        check("abort_busy", busy8, 0);
        check("abort_sum", sum8, 0);
        check("abort_cout", cout8, 0);
        for (int i = 0; i < 12; i++) tick();
        check("abort_no_result", out_valid8, 0);
        send8(8'h03, 8'h04);
        wait_valid8(n);
        check("p0304_latency", n, 8);
        check("p0304_sum", sum8, 8'h07);
        check("p0304_cout", cout8, 0);
        tick();

        // back-to-back with in_valid held high
        in_valid8 = 1'b1;
        a8 = 8'h10;
        b8 = 8'h20;
        acc = 1'b0;
        for (int k = 0; k < 50; k++) begin
            acc = in_ready8;
            tick();
            if (acc) break;
        end
        check("b2b_first_accept", acc, 1);
        a8 = 8'hF0;
        b8 = 8'h20;
        wait_valid8(n);
        check("b2b_first_latency", n, 8);
        check("b2b_first_sum", sum8, 8'h30);
        check("b2b_first_cout", cout8, 0);
        tick();
        check("b2b_idle_after_hs", in_ready8, 1);
        tick();
        check("b2b_second_busy", busy8, 1);
        in_valid8 = 1'b0;
        wait_valid8(n);
        check("b2b_second_latency", n, 8);
        check("b2b_second_sum", sum8, 8'h10);
        check("b2b_second_cout", cout8, 1);
        tick();

        // WIDTH=1 exhaustive
        out_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send1(i[1], i[0]);
            wait_valid1(n);
            check("w1_latency", n, 1);
            check("w1_sum", sum1, tbl1[i][0]);
            check("w1_cout", cout1, tbl1[i][1]);
            tick();
        end

        // random pairs with random result backpressure
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            in_valid8 = 1'b1;
            a8 = ra;
            b8 = rb;
            acc = 1'b0;
            for (int k = 0; k < 200; k++) begin
                out_ready8 = 1'($urandom_range(0, 1));
                acc = in_ready8;
                tick();
                if (acc) break;
            end
            check("rand_accept", acc, 1);
            in_valid8 = 1'b0;
        end
        out_ready8 = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (q8.size() == 0) break;
            tick();
        end
        check("rand_drained", q8.size(), 0);
        check("w1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
